// File: rtl/usb_fs_rx_pkt_parser.sv
`default_nettype none
// ============================================================================
//  Module   : usb_fs_rx_pkt_parser
//  Brief    : USB full-speed byte-level receive packet parser (PID, token
//             fields, CRC5/CRC16, payload forwarding with CRC16 stripped).
//  Revision : 1.0  initial release
// ============================================================================
module usb_fs_rx_pkt_parser #(
  parameter int MAX_DATA_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bit_sop,
  input  logic        bit_eop,
  input  logic        bit_err,
  input  logic        byte_strobe,
  input  logic [7:0]  byte_in,
  output logic        rx_pkt_start,
  output logic        rx_pkt_end,
  output logic        rx_pkt_valid,
  output logic [3:0]  rx_pid,
  output logic [6:0]  rx_addr,
  output logic [3:0]  rx_endp,
  output logic [10:0] rx_frame_num,
  output logic        rx_data_put,
  output logic [7:0]  rx_data
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PID     = 2'd1,
    S_BODY    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  localparam logic [10:0] c_cnt_max   = 11'h7FF;
  localparam logic [10:0] c_put_last  = 11'(MAX_DATA_BYTES + 2);
  localparam logic [10:0] c_len_max   = 11'(MAX_DATA_BYTES + 3);
  localparam logic [4:0]  c_crc5_init = 5'h1F;
  localparam logic [4:0]  c_crc5_res  = 5'b01100;
  localparam logic [15:0] c_crc16_init = 16'hFFFF;
  localparam logic [15:0] c_crc16_res  = 16'h800D;
  localparam logic [1:0]  c_cls_token = 2'b01;
  localparam logic [1:0]  c_cls_hs    = 2'b10;
  localparam logic [1:0]  c_cls_data  = 2'b11;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [10:0] r_cnt;
  logic [10:0] w_cnt_nxt;
  logic [4:0]  r_crc5;
  logic [4:0]  w_crc5_nxt;
  logic [15:0] r_crc16;
  logic [15:0] w_crc16_nxt;
  logic [7:0]  r_d1;
  logic [7:0]  r_d2;
  logic        w_byte;
  logic        w_pid_ok;
  logic        w_load_pid;
  logic        w_load_fields;
  logic        w_put;
  logic        w_body_after;
  logic        w_len_ok;
  logic        w_crc_ok;
  logic        w_valid;
  logic        w_end;
  logic [1:0]  w_cls;

  // Bits enter LSB first; shift-left register with feedback from the MSB.
  function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] data);
    logic [4:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[4] ^ data[i]) c = {c[3:0], 1'b0} ^ 5'h05;
      else                c = {c[3:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  always_comb begin
    w_byte        = byte_strobe && !bit_sop && !bit_err &&
                    ((r_state == S_PID) || (r_state == S_BODY));
    w_pid_ok      = (byte_in[7:4] == ~byte_in[3:0]);
    w_load_pid    = w_byte && (r_state == S_PID);
    w_cls         = w_load_pid ? byte_in[1:0] : rx_pid[1:0];

    w_cnt_nxt     = r_cnt;
    if (w_byte && (r_cnt != c_cnt_max)) w_cnt_nxt = r_cnt + 11'd1;

    w_crc5_nxt    = r_crc5;
    w_crc16_nxt   = r_crc16;
    if (w_byte && (r_state == S_BODY)) begin
      w_crc5_nxt  = crc5_byte(r_crc5, byte_in);
      w_crc16_nxt = crc16_byte(r_crc16, byte_in);
    end

    w_load_fields = w_byte && (r_state == S_BODY) && (w_cls == c_cls_token) && (r_cnt == 11'd2);
    w_put         = w_byte && (r_state == S_BODY) && (w_cls == c_cls_data) &&
                    (r_cnt >= 11'd3) && (r_cnt <= c_put_last);

    // A byte arriving together with bit_eop is counted before the end is judged.
    w_body_after  = !bit_err && ((r_state == S_BODY) || (w_load_pid && w_pid_ok));

    w_len_ok      = 1'b0;
    w_crc_ok      = 1'b0;
    case (w_cls)
      c_cls_token: begin
        w_len_ok = (w_cnt_nxt == 11'd3);
        w_crc_ok = (w_crc5_nxt == c_crc5_res);
      end
      c_cls_hs: begin
        w_len_ok = (w_cnt_nxt == 11'd1);
        w_crc_ok = 1'b1;
      end
      c_cls_data: begin
        w_len_ok = (w_cnt_nxt >= 11'd3) && (w_cnt_nxt <= c_len_max);
        w_crc_ok = (w_crc16_nxt == c_crc16_res);
      end
      default: begin
        w_len_ok = 1'b0;
        w_crc_ok = 1'b0;
      end
    endcase
    w_valid       = w_body_after && w_len_ok && w_crc_ok;
    w_end         = (r_state != S_IDLE) && (bit_sop || bit_eop);

    w_state_nxt   = r_state;
    if (bit_sop) begin
      w_state_nxt = S_PID;
    end else if (r_state != S_IDLE) begin
      if (bit_eop)         w_state_nxt = S_IDLE;
      else if (bit_err)    w_state_nxt = S_DISCARD;
      else if (w_load_pid) w_state_nxt = w_pid_ok ? S_BODY : S_DISCARD;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 11'd0;
      r_crc5       <= c_crc5_init;
      r_crc16      <= c_crc16_init;
      r_d1         <= 8'd0;
      r_d2         <= 8'd0;
      rx_pkt_start <= 1'b0;
      rx_pkt_end   <= 1'b0;
      rx_pkt_valid <= 1'b0;
      rx_pid       <= 4'd0;
      rx_addr      <= 7'd0;
      rx_endp      <= 4'd0;
      rx_frame_num <= 11'd0;
      rx_data_put  <= 1'b0;
      rx_data      <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      rx_pkt_start <= bit_sop;
      rx_pkt_end   <= w_end;
      rx_data_put  <= w_put;
      // An interrupting SYNC closes the old packet as bad.
      if (w_end) rx_pkt_valid <= bit_sop ? 1'b0 : w_valid;
      if (w_put) rx_data <= r_d2;
      if (bit_sop) begin
        r_cnt   <= 11'd0;
        r_crc5  <= c_crc5_init;
        r_crc16 <= c_crc16_init;
      end else begin
        r_cnt   <= w_cnt_nxt;
        r_crc5  <= w_crc5_nxt;
        r_crc16 <= w_crc16_nxt;
      end
      if (w_load_pid) rx_pid <= byte_in[3:0];
      if (w_load_fields) begin
        rx_addr      <= r_d1[6:0];
        rx_endp      <= {byte_in[2:0], r_d1[7]};
        rx_frame_num <= {byte_in[2:0], r_d1};
      end
      if (w_byte) begin
        r_d2 <= r_d1;
        r_d1 <= byte_in;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_fs_rx_pkt_parser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usb_fs_rx_pkt_parser
//  Brief    : Directed and randomized bench with a packet-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_usb_fs_rx_pkt_parser;
  localparam int MAXB = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        bit_sop = 1'b0, bit_eop = 1'b0, bit_err = 1'b0, byte_strobe = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        rx_pkt_start, rx_pkt_end, rx_pkt_valid, rx_data_put;
  logic [3:0]  rx_pid, rx_endp;
  logic [6:0]  rx_addr;
  logic [10:0] rx_frame_num;
  logic [7:0]  rx_data;

  usb_fs_rx_pkt_parser #(.MAX_DATA_BYTES(MAXB)) dut (
    .clk(clk), .reset_n(reset_n),
    .bit_sop(bit_sop), .bit_eop(bit_eop), .bit_err(bit_err),
    .byte_strobe(byte_strobe), .byte_in(byte_in),
    .rx_pkt_start(rx_pkt_start), .rx_pkt_end(rx_pkt_end), .rx_pkt_valid(rx_pkt_valid),
    .rx_pid(rx_pid), .rx_addr(rx_addr), .rx_endp(rx_endp), .rx_frame_num(rx_frame_num),
    .rx_data_put(rx_data_put), .rx_data(rx_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int put_seen = 0;
  bit chk_en = 0;

  // Reference model: packet bytes collected in a queue, judged at the end.
  bit          m_in, m_disc;
  logic [7:0]  m_pkt[$];
  logic [7:0]  tx[$];
  logic        exp_start, exp_end, exp_valid, exp_put;
  logic [3:0]  exp_pid, exp_endp;
  logic [6:0]  exp_addr;
  logic [10:0] exp_frame;
  logic [7:0]  exp_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [4:0] m_crc5(input logic [10:0] d);
    logic [4:0] c;
    logic fb;
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      fb = d[i] ^ c[4];
      c = {c[3:0], 1'b0};
      if (fb) c = c ^ 5'h05;
    end
    return ~c;
  endfunction

  function automatic logic [15:0] crc16_step(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    logic fb;
    c = c_in;
    for (int j = 0; j < 8; j++) begin
      fb = b[j] ^ c[15];
      c = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h8005;
    end
    return c;
  endfunction

  // Good means: the transmitted check bits equal the CRC computed from the fields.
  function automatic bit pkt_good();
    int n;
    logic [4:0]  c5;
    logic [15:0] c16;
    n = m_pkt.size();
    if (m_disc || n == 0) return 0;
    case (m_pkt[0][1:0])
      2'b10: return (n == 1);
      2'b01: begin
        if (n != 3) return 0;
        c5 = m_crc5({m_pkt[2][2:0], m_pkt[1]});
        for (int i = 0; i < 5; i++) if (m_pkt[2][3+i] != c5[4-i]) return 0;
        return 1;
      end
      2'b11: begin
        if (n < 3 || (n - 3) > MAXB) return 0;
        c16 = 16'hFFFF;
        for (int i = 1; i <= n - 3; i++) c16 = crc16_step(c16, m_pkt[i]);
        c16 = ~c16;
        for (int j = 0; j < 8; j++) begin
          if (m_pkt[n-2][j] != c16[15-j]) return 0;
          if (m_pkt[n-1][j] != c16[7-j])  return 0;
        end
        return 1;
      end
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_in = 0; m_disc = 0; m_pkt.delete();
    exp_start = 0; exp_end = 0; exp_valid = 0; exp_put = 0;
    exp_pid = 0; exp_endp = 0; exp_addr = 0; exp_frame = 0; exp_data = 0;
  endtask

  task automatic model_step(input bit sop, input bit eop, input bit err, input bit stb, input logic [7:0] b);
    int n;
    logic [3:0] inv;
    exp_start = sop; exp_end = 0; exp_put = 0;
    if (sop) begin
      if (m_in) begin exp_end = 1; exp_valid = 0; end
      m_in = 1; m_disc = 0; m_pkt.delete();
      return;
    end
    if (!m_in) return;
    if (err) m_disc = 1;
    else if (stb && !m_disc) begin
      m_pkt.push_back(b);
      n = m_pkt.size();
      if (n == 1) begin
        exp_pid = b[3:0];
        inv = ~b[3:0];
        if (b[7:4] != inv) m_disc = 1;
      end else if (m_pkt[0][1:0] == 2'b01 && n == 3) begin
        exp_addr  = m_pkt[1][6:0];
        exp_endp  = {m_pkt[2][2:0], m_pkt[1][7]};
        exp_frame = {m_pkt[2][2:0], m_pkt[1]};
      end else if (m_pkt[0][1:0] == 2'b11 && n >= 4 && (n - 3) <= MAXB) begin
        exp_put = 1;
        exp_data = m_pkt[n-3];
      end
    end
    if (eop) begin exp_end = 1; exp_valid = pkt_good(); m_in = 0; end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("pkt_start", rx_pkt_start, exp_start);
      check("pkt_end", rx_pkt_end, exp_end);
      check("pkt_valid", rx_pkt_valid, exp_valid);
      check("pid", rx_pid, exp_pid);
      check("addr", rx_addr, exp_addr);
      check("endp", rx_endp, exp_endp);
      check("frame_num", rx_frame_num, exp_frame);
      check("data_put", rx_data_put, exp_put);
      check("data", rx_data, exp_data);
      if (rx_data_put) put_seen++;
    end
  end

  task automatic cyc(input bit sop, input bit eop, input bit err, input bit stb, input logic [7:0] b);
    @(posedge clk); #3;
    bit_sop = sop; bit_eop = eop; bit_err = err; byte_strobe = stb; byte_in = b;
    model_step(sop, eop, err, stb, b);
  endtask

  task automatic send(input bit gaps, input bit eop_last, input int err_at, input bit no_eop);
    bit ended;
    int n;
    ended = 0;
    n = tx.size();
    put_seen = 0;
    cyc(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) cyc(0, 0, 0, 0, 8'($urandom));
      if (i == err_at) cyc(0, 0, 1, 0, 8'h00);
      if (eop_last && !no_eop && i == n - 1 && err_at < n) begin
        cyc(0, 1, 0, 1, tx[i]); ended = 1;
      end else cyc(0, 0, 0, 1, tx[i]);
    end
    if (err_at >= n) cyc(0, 0, 1, 0, 8'h00);
    if (!no_eop && !ended) cyc(0, 1, 0, 0, 8'h00);
    if (!no_eop) repeat (2) cyc(0, 0, 0, 0, 8'h00);
  endtask

  task automatic build_token(input logic [3:0] p, input logic [10:0] d, input bit corrupt);
    logic [4:0] c;
    logic [7:0] b2;
    c = m_crc5(d);
    b2 = {5'd0, d[10:8]};
    for (int i = 0; i < 5; i++) b2[3+i] = c[4-i];
    tx.delete();
    tx.push_back({~p, p});
    tx.push_back(d[7:0]);
    tx.push_back(b2);
    if (corrupt) tx[1 + $urandom_range(0, 1)][$urandom_range(0, 7)] ^= 1'b1;
  endtask

  task automatic build_data(input logic [3:0] p, input int len, input bit corrupt);
    logic [15:0] c;
    logic [7:0] r, x0, x1;
    tx.delete();
    tx.push_back({~p, p});
    c = 16'hFFFF;
    for (int i = 0; i < len; i++) begin
      r = 8'($urandom);
      tx.push_back(r);
      c = crc16_step(c, r);
    end
    c = ~c;
    for (int j = 0; j < 8; j++) begin x0[j] = c[15-j]; x1[j] = c[7-j]; end
    tx.push_back(x0);
    tx.push_back(x1);
    if (corrupt) tx[$urandom_range(1, tx.size() - 1)][$urandom_range(0, 7)] ^= 1'b1;
  endtask

  task automatic reset_mid();
    @(posedge clk); #3;
    reset_n = 1'b0;
    bit_sop = 0; bit_eop = 0; bit_err = 0; byte_strobe = 0;
    model_reset();
    #1;
    check("rst_now_end", rx_pkt_end, 0);
    check("rst_now_pid", rx_pid, 0);
    check("rst_now_valid", rx_pkt_valid, 0);
    repeat (2) cyc(0, 0, 0, 0, 8'h00);
    @(posedge clk); #3;
    reset_n = 1'b1;
  endtask

  initial begin
    int kind, len, err_at;
    bit corrupt;
    logic [3:0] p;
    #1 reset_n = 1'b0;
    model_reset();
    chk_en = 1;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (2) cyc(0, 0, 0, 0, 8'h00);

    // Hand-computed expectations pin the model and the design.
    tx = '{8'hE1, 8'h00, 8'h10};
    send(0, 0, -1, 0);
    check("lit_tok_valid", rx_pkt_valid, 1);
    check("lit_tok_model", exp_valid, 1);
    check("lit_tok_pid", rx_pid, 4'h1);
    check("lit_tok_addr", rx_addr, 0);
    check("lit_tok_puts", put_seen, 0);

    tx = '{8'hE1, 8'h00, 8'h11};
    send(0, 0, -1, 0);
    check("lit_badcrc_valid", rx_pkt_valid, 0);
    check("lit_badcrc_endp", rx_endp, 4'h2);
    check("lit_badcrc_frame", rx_frame_num, 11'h100);

    tx = '{8'h4B, 8'h00, 8'h00};
    send(0, 0, -1, 0);
    check("lit_zlp1_valid", rx_pkt_valid, 1);
    check("lit_zlp1_pid", rx_pid, 4'hB);
    check("lit_zlp1_puts", put_seen, 0);

    tx = '{8'hC3, 8'h00, 8'h00};
    send(0, 0, -1, 0);
    check("lit_zlp0_valid", rx_pkt_valid, 1);
    check("lit_zlp0_pid", rx_pid, 4'h3);

    build_data(4'h3, 4, 0);
    tx[1] = 8'h01; tx[2] = 8'h02; tx[3] = 8'h03; tx[4] = 8'h04;
    build_data_fixup();
    send(0, 0, -1, 0);
    check("lit_d4_valid", rx_pkt_valid, 1);
    check("lit_d4_puts", put_seen, 4);
    check("lit_d4_last", rx_data, 8'h04);
    tx[2] ^= 8'h10;
    send(0, 0, -1, 0);
    check("lit_d4bad_valid", rx_pkt_valid, 0);
    check("lit_d4bad_puts", put_seen, 4);

    tx = '{8'hA5};
    send(0, 0, -1, 0);
    check("lit_a5_valid", rx_pkt_valid, 0);
    tx = '{8'hD2};
    send(0, 0, -1, 0);
    check("lit_ack_valid", rx_pkt_valid, 1);
    tx = '{8'hD2, 8'h00};
    send(0, 0, -1, 0);
    check("lit_ackx_valid", rx_pkt_valid, 0);

    tx = '{8'hC3, 8'h11, 8'h22};
    send(0, 0, -1, 1);
    reset_mid();
    tx = '{8'hE1, 8'h00, 8'h10};
    send(0, 1, -1, 0);
    check("lit_after_rst_valid", rx_pkt_valid, 1);

    for (int k = 0; k < 160; k++) begin
      kind = $urandom_range(0, 5);
      corrupt = ($urandom_range(0, 5) == 0);
      case (kind)
        0: begin
          case ($urandom_range(0, 2)) 0: p = 4'h1; 1: p = 4'h9; default: p = 4'hD; endcase
          build_token(p, 11'($urandom), corrupt);
        end
        1: begin
          case ($urandom_range(0, 2)) 0: p = 4'h2; 1: p = 4'hA; default: p = 4'hE; endcase
          tx.delete(); tx.push_back({~p, p});
          if (corrupt) tx.push_back(8'($urandom));
        end
        2: begin
          len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(62, 70)) : int'($urandom_range(0, 12));
          build_data(($urandom_range(0, 1) == 0) ? 4'h3 : 4'hB, len, corrupt);
        end
        3: begin
          tx.delete(); tx.push_back(8'($urandom));
          repeat ($urandom_range(0, 4)) tx.push_back(8'($urandom));
        end
        4: build_token(4'h5, 11'($urandom), corrupt);
        default: begin
          p = {2'($urandom), 2'b00};
          tx.delete(); tx.push_back({~p, p});
          repeat ($urandom_range(0, 3)) tx.push_back(8'($urandom));
        end
      endcase
      err_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, tx.size())) : -1;
      send($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, err_at, $urandom_range(0, 11) == 0);
    end
    cyc(0, 1, 0, 0, 8'h00);
    repeat (3) cyc(0, 0, 0, 0, 8'h00);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Recompute the CRC16 bytes of tx after its payload has been overwritten.
  task automatic build_data_fixup();
    logic [15:0] c;
    logic [7:0] x0, x1;
    int n;
    n = tx.size();
    c = 16'hFFFF;
    for (int i = 1; i <= n - 3; i++) c = crc16_step(c, tx[i]);
    c = ~c;
    for (int j = 0; j < 8; j++) begin x0[j] = c[15-j]; x1[j] = c[7-j]; end
    tx[n-2] = x0;
    tx[n-1] = x1;
  endtask

endmodule
`default_nettype wire
